// File: rtl/ins_load_ctrl.sv
// Instruction-ROM loader: assembles a little-endian byte stream into 32-bit
// words, writes them through the loader side of the ROM mux, and keeps the
// RISC core in reset until a complete image has been written.
module ins_load_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] ins_addr_nap,
  output logic [31:0] ins_data_nap,
  output logic        we_cpu,
  output logic        sel,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_idx, idx_next;
  logic [23:0] len_buf, len_next;
  logic [23:0] word_buf, wbuf_next;
  logic [31:0] words_left, left_next;
  logic [31:0] idle_cnt, idle_next;
  logic [31:0] addr_next, data_next;
  logic [15:0] cnt_next;
  logic [31:0] len_full;
  logic        timeout_hit;

  // The fourth byte completes a field, so the full value combines the
  // live byte with the three bytes already captured.
  assign len_full    = {rx_data, len_buf};
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((idle_cnt + 32'd1) >= TIMEOUT_CYC);

  // Next-state and datapath: everything is computed here and registered below.
  always_comb begin
    state_next = state;
    idx_next   = byte_idx;
    len_next   = len_buf;
    wbuf_next  = word_buf;
    left_next  = words_left;
    idle_next  = idle_cnt;
    addr_next  = ins_addr_nap;
    data_next  = ins_data_nap;
    cnt_next   = word_cnt;
    case (state)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          state_next = LEN;
          idx_next   = 2'd0;
          idle_next  = 32'd0;
        end
      end
      LEN: begin
        if (rx_valid) begin
          idle_next = 32'd0;
          idx_next  = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: len_next[7:0]   = rx_data;
            2'd1: len_next[15:8]  = rx_data;
            2'd2: len_next[23:16] = rx_data;
            default: begin
              if (len_full == 32'd0 || len_full > MAX_WORDS) begin
                state_next = ERR;
              end else begin
                state_next = DATA;
                addr_next  = BASE_ADDR;
                left_next  = len_full;
                cnt_next   = 16'd0;
                idx_next   = 2'd0;
              end
            end
          endcase
        end else if (timeout_hit) begin
          state_next = ERR;
        end else begin
          idle_next = idle_cnt + 32'd1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          idle_next = 32'd0;
          idx_next  = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: wbuf_next[7:0]   = rx_data;
            2'd1: wbuf_next[15:8]  = rx_data;
            2'd2: wbuf_next[23:16] = rx_data;
            default: begin
              state_next = WRITE;
              data_next  = {rx_data, word_buf};
            end
          endcase
        end else if (timeout_hit) begin
          state_next = ERR;
        end else begin
          idle_next = idle_cnt + 32'd1;
        end
      end
      WRITE: begin
        addr_next  = ins_addr_nap + 32'd4;
        cnt_next   = word_cnt + 16'd1;
        left_next  = words_left - 32'd1;
        state_next = (words_left == 32'd1) ? DONE : DATA;
        idx_next   = 2'd0;
        if (rx_valid) begin
          wbuf_next[7:0] = rx_data;
          idx_next       = 2'd1;
          idle_next      = 32'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and status outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      len_buf      <= 24'd0;
      word_buf     <= 24'd0;
      words_left   <= 32'd0;
      idle_cnt     <= 32'd0;
      ins_addr_nap <= BASE_ADDR;
      ins_data_nap <= 32'd0;
      word_cnt     <= 16'd0;
      we_cpu       <= 1'b0;
      sel          <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      byte_idx     <= idx_next;
      len_buf      <= len_next;
      word_buf     <= wbuf_next;
      words_left   <= left_next;
      idle_cnt     <= idle_next;
      ins_addr_nap <= addr_next;
      ins_data_nap <= data_next;
      word_cnt     <= cnt_next;
      we_cpu       <= (state_next == WRITE);
      sel          <= (state_next == DONE);
      cpu_rst      <= (state_next != DONE);
      busy         <= (state_next == LEN) || (state_next == DATA) || (state_next == WRITE);
      done         <= (state_next == DONE);
      err          <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_ins_load_ctrl.sv
// Self-checking bench for ins_load_ctrl: directed and randomized images
// compared against a word-level model of the expected ROM writes.
module tb_ins_load_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] ins_addr_nap, ins_data_nap;
  logic        we_cpu, sel, cpu_rst, busy, done, err;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] img_words[$];
  logic [7:0]  img_bytes[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  ins_load_ctrl #(.BASE_ADDR(BASE), .MAX_WORDS(1024), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data),
    .rx_valid(rx_valid), .ins_addr_nap(ins_addr_nap), .ins_data_nap(ins_data_nap),
    .we_cpu(we_cpu), .sel(sel), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every ROM write and confirm the mux never points at the CPU then.
  always @(negedge clk) begin
    if (we_cpu) begin
      wr_addr_q.push_back(ins_addr_nap);
      wr_data_q.push_back(ins_data_nap);
      checkOutput("sel_low_during_write", 32'(sel), 32'd0);
    end
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialise img_words as a length-prefixed little-endian byte image.
  task automatic buildStream();
    logic [31:0] w;
    img_bytes.delete();
    w = 32'(img_words.size());
    for (int b = 0; b < 4; b++) img_bytes.push_back(w[8*b +: 8]);
    foreach (img_words[i]) begin
      w = img_words[i];
      for (int b = 0; b < 4; b++) img_bytes.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic pulseLoad(input bit with_byte);
    load_req = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
    end
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Send the first n bytes of img_bytes with random gaps of 0..gap_max.
  task automatic applyStimulus(input int n, input int gap_max, input bit poke_busy);
    for (int i = 0; i < n; i++) begin
      rx_data  = img_bytes[i];
      rx_valid = 1'b1;
      load_req = poke_busy && (i == 2 || i == 6);
      tick();
      rx_valid = 1'b0;
      load_req = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic waitSettle();
    for (int c = 0; c < 64 && !(done || err); c++) tick();
    tick();
    tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sel"}, 32'(sel), 32'd0);
    checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, "_we"}, 32'(we_cpu), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_addr"}, ins_addr_nap, BASE);
    checkOutput({tag, "_data"}, ins_data_nap, 32'd0);
    checkOutput({tag, "_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  // Expected: word i of the image lands at BASE + 4*i, then the CPU runs.
  task automatic checkLoad(input string tag);
    checkOutput({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(img_words.size()));
    for (int i = 0; i < img_words.size() && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
      checkOutput($sformatf("%s_data%0d", tag, i), wr_data_q[i], img_words[i]);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_sel"}, 32'(sel), 32'd1);
    checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(word_cnt), 32'(img_words.size()));
  endtask

  task automatic runLoad(input string tag, input int gap_max, input bit poke_busy, input bit with_byte);
    buildStream();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulseLoad(with_byte);
    checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_start_sel"}, 32'(sel), 32'd0);
    checkOutput({tag, "_start_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
    applyStimulus(img_bytes.size(), gap_max, poke_busy);
    waitSettle();
    checkLoad(tag);
  endtask

  task automatic runBad(input string tag, input logic [31:0] len);
    img_bytes.delete();
    for (int b = 0; b < 4; b++) img_bytes.push_back(len[8*b +: 8]);
    wr_addr_q.delete();
    pulseLoad(1'b0);
    applyStimulus(4, 1, 1'b0);
    waitSettle();
    checkOutput({tag, "_err"}, 32'(err), 32'd1);
    checkOutput({tag, "_sel"}, 32'(sel), 32'd0);
    checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd0);
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkReset("reset");

    // Bytes in IDLE must be ignored.
    img_bytes = '{8'h01, 8'h00, 8'h00};
    wr_addr_q.delete();
    applyStimulus(3, 0, 1'b0);
    checkOutput("idle_bytes_busy", 32'(busy), 32'd0);
    checkOutput("idle_bytes_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Reference 2-word image with gaps between bytes.
    img_words = '{32'hDEAD_BEEF, 32'h1234_5678};
    runLoad("two_word_gap", 3, 1'b0, 1'b0);

    // Reload from DONE with a 1-word image, back-to-back.
    img_words = '{32'h0000_0013};
    runLoad("reload_one", 0, 1'b0, 1'b0);

    // Same 2-word image, back-to-back so a byte lands during WRITE.
    img_words = '{32'hDEAD_BEEF, 32'h1234_5678};
    runLoad("two_word_b2b", 0, 1'b0, 1'b0);

    // Bad lengths.
    runBad("len_zero", 32'd0);
    runBad("len_1025", 32'd1025);

    // Timeout after a partial word.
    img_bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    wr_addr_q.delete();
    pulseLoad(1'b0);
    checkOutput("to_err_cleared", 32'(err), 32'd0);
    applyStimulus(6, 0, 1'b0);
    repeat (95) tick();
    checkOutput("to_before_err", 32'(err), 32'd0);
    checkOutput("to_before_busy", 32'(busy), 32'd1);
    repeat (7) tick();
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("to_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Mid-load reset after 6 data bytes: only the first word was written.
    img_words = '{32'hCAFE_F00D, 32'h0BAD_1DEA};
    buildStream();
    wr_addr_q.delete();
    pulseLoad(1'b0);
    applyStimulus(10, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("midrst");
    tick();
    checkOutput("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
    runLoad("after_midrst", 2, 1'b0, 1'b0);

    // Load request with a simultaneous byte in DONE: byte ignored.
    img_words = '{32'h7654_3210, 32'h0F0F_A5A5, 32'h8000_0001};
    runLoad("req_with_byte", 1, 1'b0, 1'b1);

    // Randomized images, gaps and ignored load requests while busy.
    for (int r = 0; r < 6; r++) begin
      img_words.delete();
      repeat ($urandom_range(1, 6)) img_words.push_back($urandom);
      runLoad($sformatf("rand%0d", r), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
